// File: rtl/pwm_pkg.sv
// pwm_pkg
//   Shared defaults and helpers for the PWM generator.
//   PWM_WIDTH_DEF : default width of the duty input and the period counter
//   PWM_DIV_DEF   : default prescale ratio (clocks per counter tick)
//   pwm_max()     : last counter value of a period, 2^width-2, so that a
//                   period spans 2^width-1 ticks and the all-ones duty code
//                   is never reached by the counter (100% duty).
package pwm_pkg;

  localparam int PWM_WIDTH_DEF = 4;
  localparam int PWM_DIV_DEF   = 1;

  function automatic int pwm_max(input int width);
    return (1 << width) - 2;
  endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// pwm_prescaler
//   Free-running clock-enable generator. Counts 0..DIV-1 and asserts tick
//   while the count equals DIV-1, then wraps. DIV=1 gives tick every cycle.
// Ports
//   CLK  : system clock, rising edge
//   RST  : asynchronous active-high reset (count returns to 0)
//   tick : one-cycle clock enable for the period counter
module pwm_prescaler
  import pwm_pkg::*;
#(
  parameter int DIV = PWM_DIV_DEF
) (
  input  logic CLK,
  input  logic RST,
  output logic tick
);

  // Keep at least one bit so DIV=1 still has a legal (constant-zero) counter.
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    tick    = (count_q == LAST);
    count_d = tick ? '0 : count_q + 1'b1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/pwm_gen.sv
// pwm_gen
//   Registered PWM generator with a prescaled period counter and a duty
//   shadow register that only updates at period start (glitch-free).
//   Period is 2^WIDTH-1 ticks; duty d gives d high ticks per period,
//   0 gives constant low and 2^WIDTH-1 gives constant high.
// Ports
//   CLK   : system clock, rising edge
//   RST   : asynchronous active-high reset; forces OUT low immediately
//   Input : requested duty, unsigned 0..2^WIDTH-1
//   OUT   : registered PWM waveform (one clock behind the compare)
module pwm_gen
  import pwm_pkg::*;
#(
  parameter int WIDTH = PWM_WIDTH_DEF,
  parameter int DIV   = PWM_DIV_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] Input,
  output logic             OUT
);

  localparam logic [WIDTH-1:0] MAX = WIDTH'(pwm_max(WIDTH));

  generate
    if (DIV < 1) begin : g_bad_div
      $error("pwm_gen: DIV must be >= 1");
    end
    if (WIDTH < 2) begin : g_bad_width
      $error("pwm_gen: WIDTH must be >= 2");
    end
  endgenerate

  logic             tick;
  logic             wrap;
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;
  logic [WIDTH-1:0] duty_sh_q;
  logic [WIDTH-1:0] duty_sh_d;
  logic             out_q;
  logic             out_d;

  pwm_prescaler #(
    .DIV (DIV)
  ) u_prescaler (
    .CLK  (CLK),
    .RST  (RST),
    .tick (tick)
  );

  always_comb begin
    wrap      = (cnt_q == MAX);
    cnt_d     = cnt_q;
    duty_sh_d = duty_sh_q;
    if (tick) begin
      if (wrap) begin
        // Period boundary: the only point where a new duty is accepted.
        cnt_d     = '0;
        duty_sh_d = Input;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    // cnt never reaches all-ones, so duty all-ones is always high.
    out_d = (cnt_q < duty_sh_q);
  end

  // Counter resets to MAX so the first tick after reset wraps and loads
  // the duty straight away instead of waiting a full period.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q     <= MAX;
      duty_sh_q <= '0;
      out_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      duty_sh_q <= duty_sh_d;
      out_q     <= out_d;
    end
  end

  assign OUT = out_q;

endmodule

// File: tb/tb_pwm_gen.sv
module tb_pwm_gen;

  logic       clk = 1'b0;
  logic       rst1;
  logic       rst4;
  logic [3:0] in1;
  logic [3:0] in4;
  logic       out1;
  logic       out4;

  always #5 clk = ~clk;

  pwm_gen #(.WIDTH(4), .DIV(1)) u_div1 (
    .CLK   (clk),
    .RST   (rst1),
    .Input (in1),
    .OUT   (out1)
  );

  pwm_gen #(.WIDTH(4), .DIV(4)) u_div4 (
    .CLK   (clk),
    .RST   (rst4),
    .Input (in4),
    .OUT   (out4)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] duty;      // applied Input
    int         exp_high;  // hand-computed high clocks per 15-clock period
    int         nclk;      // clocks observed after reset release
  } vec_t;

  vec_t vecs[6];

  task automatic chk_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0b required=%0b", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hold reset 100 ns, present duty, release just after an edge so the
  // next rising edge is edge 1 of the run.
  task automatic reset_div1(input logic [3:0] duty);
    rst1 = 1'b1;
    in1  = duty;
    #100;
    step();
    chk_bit("div1_out_in_reset", out1, 1'b0);
    rst1 = 1'b0;
  endtask

  initial begin
    logic exp;
    int   hi;
    int   pos;
    int   per;
    int   d;

    vecs[0] = '{duty: 4'd15, exp_high: 15, nclk: 46};
    vecs[1] = '{duty: 4'd0,  exp_high: 0,  nclk: 46};
    vecs[2] = '{duty: 4'd5,  exp_high: 5,  nclk: 46};
    vecs[3] = '{duty: 4'd10, exp_high: 10, nclk: 46};
    vecs[4] = '{duty: 4'd1,  exp_high: 1,  nclk: 46};
    vecs[5] = '{duty: 4'd14, exp_high: 14, nclk: 46};

    rst1 = 1'b0;
    rst4 = 1'b0;
    in1  = 4'd0;
    in4  = 4'd5;
    #1;
    rst1 = 1'b1;
    rst4 = 1'b1;
    #2;
    chk_bit("reset_state_div1", out1, 1'b0);
    chk_bit("reset_state_div4", out4, 1'b0);

    // Table: edge 1 after release wraps/loads (OUT still 0), then OUT after
    // edge k is high for the first exp_high clocks of each 15-clock period.
    for (int v = 0; v < 6; v++) begin
      reset_div1(vecs[v].duty);
      hi = 0;
      for (int k = 1; k <= vecs[v].nclk; k++) begin
        step();
        exp = (k >= 2) && (((k - 2) % 15) < vecs[v].exp_high);
        chk_bit($sformatf("duty%0d_clk%0d", vecs[v].duty, k), out1, exp);
        if (k >= 32 && out1 === 1'b1) hi++;
      end
      chk_int($sformatf("duty%0d_high_per_period", vecs[v].duty), hi, vecs[v].exp_high);
    end

    // Mid-period update 5 -> 10 while cnt=3 (after edge 4); the running
    // period keeps 5 high, later periods show 10 high / 5 low. Re-writing
    // the same value later must change nothing.
    reset_div1(4'd5);
    for (int k = 1; k <= 46; k++) begin
      step();
      per = (k - 2) / 15;
      pos = (k - 2) % 15;
      d   = (per == 0) ? 5 : 10;
      exp = (k >= 2) && (pos < d);
      chk_bit($sformatf("update_clk%0d", k), out1, exp);
      if (k == 4)  in1 = 4'd10;
      if (k == 20) in1 = 4'd10;
    end

    // Reset mid-operation: OUT must fall with no clock edge.
    reset_div1(4'd15);
    for (int k = 1; k <= 5; k++) step();
    chk_bit("pre_async_rst_high", out1, 1'b1);
    #3;
    rst1 = 1'b1;
    #1;
    chk_bit("async_rst_drop", out1, 1'b0);
    #100;
    step();
    chk_bit("async_rst_hold", out1, 1'b0);
    in1  = 4'd5;
    rst1 = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      exp = (k >= 2) && ((k - 2) < 5);
      chk_bit($sformatf("restart_clk%0d", k), out1, exp);
    end

    // DIV=4, duty 5: first tick on edge 4, then 20 clocks high from
    // edge 5, 40 low, period 60.
    in4 = 4'd5;
    step();
    chk_bit("div4_out_in_reset", out4, 1'b0);
    rst4 = 1'b0;
    hi = 0;
    for (int k = 1; k <= 130; k++) begin
      step();
      exp = (k >= 5) && (((k - 5) % 60) < 20);
      chk_bit($sformatf("div4_clk%0d", k), out4, exp);
      if (k >= 65 && k <= 124 && out4 === 1'b1) hi++;
    end
    chk_int("div4_high_per_period", hi, 20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_gen.md
PWM_GEN -- requirements
Module: pwm_gen

Interface
REQ-001 SHALL provide parameter: WIDTH, 4, bit width of the duty input and the period counter.
REQ-002 SHALL provide parameter: DIV, 1, clock-enable prescale ratio, clocks per counter tick, legal DIV >= 1.
REQ-003 SHALL provide port: CLK  input  1  single system clock, rising-edge active.
REQ-004 SHALL provide port: RST  input  1  asynchronous, active-high reset.
REQ-005 SHALL provide port: Input  input  WIDTH  requested duty value, unsigned 0..2^WIDTH-1.
REQ-006 SHALL provide port: OUT  output  1  registered PWM waveform.
REQ-007 SHALL use one clock; reset is asynchronous and active-high.

Function
REQ-008 SHALL hold a prescaler counting 0..DIV-1 on every CLK edge; tick SHALL be asserted in the cycle it equals DIV-1, then it wraps to 0; DIV=1 gives tick every cycle.
REQ-009 SHALL hold period counter cnt of WIDTH bits, range 0..MAX, with MAX = 2^WIDTH-2, giving a period of 2^WIDTH-1 ticks (15 for WIDTH=4).
REQ-010 SHALL, on a tick edge, set cnt to 0 if cnt==MAX, else increment cnt; no tick SHALL mean cnt holds.
REQ-011 SHALL hold shadow register duty_sh; on the tick edge where cnt wraps MAX->0 it SHALL load Input; at all other times duty_sh holds, so Input changes take effect only at period start (glitch-free).
REQ-012 SHALL register OUT on every CLK edge as OUT <= (cnt < duty_sh), using pre-edge values, which is one clock of latency.
REQ-013 SHALL give duty 0 a constant-low OUT; duty 2^WIDTH-1 SHALL give constant-high OUT (100%); duty d SHALL give d high ticks then MAX+1-d low ticks per period.
REQ-014 SHALL compare unsigned at WIDTH bits and SHALL create no overflow; cnt never reaches 2^WIDTH-1.
REQ-015 SHALL treat an Input change mid-period as ignored until the next MAX->0 wrap; Input equal to the current duty_sh SHALL cause no visible change.
REQ-016 SHALL, when tick and wrap coincide with RST assertion, let reset win.

Reset
REQ-017 SHALL, while RST is high, force asynchronously OUT=0, duty_sh=0, prescaler=0, cnt=MAX.
REQ-018 SHALL, after RST deasserts, load Input into duty_sh at the first tick, because cnt starts at MAX, with no full-period wait.
REQ-019 SHALL, if RST asserts mid-operation, drop OUT low immediately, without waiting for a clock edge, and restart from REQ-017 state.

Structure
REQ-020 SHALL place the WIDTH default, DIV default and a MAX-derivation function in shared package pwm_pkg.
REQ-021 SHALL implement the prescaler as sub-module pwm_prescaler (ports CLK, RST, tick), instantiated once; counter, shadow and comparator SHALL stay in pwm_gen.
REQ-022 SHALL check DIV >= 1 and WIDTH >= 2 at elaboration.

Verification
REQ-023 SHALL cover full duty: RST=1 100 ns, then RST=0 and Input=4'b1111, DIV=1 -> OUT low at 1st edge, high from 2nd edge onward, never low again.
REQ-024 SHALL cover zero duty: Input=0 after reset -> OUT stays 0 for >= 3 periods (45 clocks).
REQ-025 SHALL cover partial duty: Input=5, DIV=1 -> steady state repeats 5 clocks high, 10 clocks low, period 15.
REQ-026 SHALL cover a mid-period update: Input 5->10 while cnt=3 -> current period keeps 5 high; next period shows 10 high, 5 low.
REQ-027 SHALL cover the prescaler: DIV=4, Input=5 -> 20 clocks high, 40 clocks low, period 60 clocks.
REQ-028 SHALL cover reset mid-operation: RST asserted while OUT=1 -> OUT=0 within the same timestep, without a clock edge; after release the sequence restarts per REQ-018.
